// File: rtl/and_gate.sv
// and_gate: bitwise two-input AND with a zero-latency output, a registered
// copy, and a small activity monitor (reductions, rising-edge pulse and a
// saturating count of cycles where every bit of A & B was high).

// One bit of the AND. It is replicated across WIDTH by the top level.
module and_gate_lane (
   input  logic a_i,
   input  logic b_i,
   output logic y_o
);
   assign y_o = a_i & b_i;
endmodule

module and_gate #(
   parameter int WIDTH = 1,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             en,
   input  logic             clr_cnt,
   output logic [WIDTH-1:0] Y,
   output logic [WIDTH-1:0] Y_q,
   output logic             all_q,
   output logic             any_q,
   output logic             rise_p,
   output logic [CNT_W-1:0] hi_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [WIDTH-1:0] and_w;
   logic             all_w;
   logic             any_w;

   logic [WIDTH-1:0] yreg_q, yreg_d;
   logic             all_r_q, all_r_d;
   logic             any_r_q, any_r_d;
   logic             rise_r_q, rise_r_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Per-bit AND lanes; Y never passes through a register, so it does not
   // care about clk, rst or en.
   for (genvar g = 0; g < WIDTH; g++) begin : g_lane
      and_gate_lane u_lane (
         .a_i (A[g]),
         .b_i (B[g]),
         .y_o (and_w[g])
      );
   end

   assign all_w = &and_w;
   assign any_w = |and_w;

   // Next-state: registered copies follow the AND only while enabled; the
   // counter looks at the already-registered all flag, so it trails by one.
   always_comb begin
      yreg_d   = yreg_q;
      all_r_d  = all_r_q;
      any_r_d  = any_r_q;
      rise_r_d = en & ~all_r_q & all_w;
      cnt_d    = cnt_q;
      if (en) begin
         yreg_d  = and_w;
         all_r_d = all_w;
         any_r_d = any_w;
      end
      if (clr_cnt) begin
         cnt_d = '0;
      end else if (en && all_r_q && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_ONE;
      end
   end

   // State registers with synchronous reset taking priority over everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         yreg_q   <= '0;
         all_r_q  <= 1'b0;
         any_r_q  <= 1'b0;
         rise_r_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         yreg_q   <= yreg_d;
         all_r_q  <= all_r_d;
         any_r_q  <= any_r_d;
         rise_r_q <= rise_r_d;
         cnt_q    <= cnt_d;
      end
   end

   assign Y      = and_w;
   assign Y_q    = yreg_q;
   assign all_q  = all_r_q;
   assign any_q  = any_r_q;
   assign rise_p = rise_r_q;
   assign hi_cnt = cnt_q;

endmodule

// File: tb/tb_and_gate.sv
// Bench for and_gate: a WIDTH=4 / CNT_W=3 instance driven through directed
// vectors and checked every cycle against a behavioural model, plus a
// WIDTH=1 instance for the truth table and the reduction-equals-copy case.
module tb_and_gate;

   logic clk = 1'b0;
   logic rst = 1'b0;

   // WIDTH = 4, CNT_W = 3 instance
   logic [3:0] a4 = '0, b4 = '0, y4, yq4;
   logic       en4 = 1'b1, clr4 = 1'b0;
   logic       all4, any4, rise4;
   logic [2:0] cnt4;

   // WIDTH = 1 instance
   logic       a1 = 1'b0, b1 = 1'b0, y1, yq1, all1, any1, rise1;
   logic [15:0] cnt1;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   and_gate #(.WIDTH(4), .CNT_W(3)) dut4 (
      .clk(clk), .rst(rst), .A(a4), .B(b4), .en(en4), .clr_cnt(clr4),
      .Y(y4), .Y_q(yq4), .all_q(all4), .any_q(any4), .rise_p(rise4), .hi_cnt(cnt4)
   );

   and_gate #(.WIDTH(1), .CNT_W(16)) dut1 (
      .clk(clk), .rst(rst), .A(a1), .B(b1), .en(1'b1), .clr_cnt(1'b0),
      .Y(y1), .Y_q(yq1), .all_q(all1), .any_q(any1), .rise_p(rise1), .hi_cnt(cnt1)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: what each output must be after the next edge,
   // stated directly from the rules (all-ones test, nonzero test, min()).
   logic [3:0] m_yq;
   logic       m_all, m_any, m_rise, m_yq1;
   int         m_cnt;
   logic       mvalid = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         m_yq <= 4'h0; m_all <= 1'b0; m_any <= 1'b0; m_rise <= 1'b0;
         m_cnt <= 0; m_yq1 <= 1'b0; mvalid <= 1'b1;
      end else begin
         m_yq1  <= a1 & b1;
         m_rise <= en4 && !m_all && ((a4 & b4) == 4'hF);
         if (en4) begin
            m_yq  <= a4 & b4;
            m_all <= ((a4 & b4) == 4'hF);
            m_any <= ((a4 & b4) != 4'h0);
         end
         if (clr4)             m_cnt <= 0;
         else if (en4 && m_all) m_cnt <= (m_cnt + 1 > 7) ? 7 : m_cnt + 1;
      end
   end

   // Per-cycle compare, mid-cycle on the falling edge.
   always @(negedge clk) begin
      chk("Y4_comb", 32'(y4), 32'(a4 & b4));
      chk("Y1_comb", 32'(y1), 32'(a1 & b1));
      if (mvalid) begin
         chk("Y_q",    32'(yq4),   32'(m_yq));
         chk("all_q",  32'(all4),  32'(m_all));
         chk("any_q",  32'(any4),  32'(m_any));
         chk("rise_p", 32'(rise4), 32'(m_rise));
         chk("hi_cnt", 32'(cnt4),  32'(m_cnt));
         chk("w1_Y_q",   32'(yq1),  32'(m_yq1));
         chk("w1_all_q", 32'(all1), 32'(m_yq1));
         chk("w1_any_q", 32'(any1), 32'(m_yq1));
      end
   end

   // Advance n rising edges, leaving time 2 units past the last edge.
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   initial begin : watchdog
      #50000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

   initial begin
      // Combinational truth table on the WIDTH=1 instance: 00,10,01,11.
      a1 = 0; b1 = 0; #1 chk("tt_00", 32'(y1), 32'd0); #6;
      a1 = 1; b1 = 0; #1 chk("tt_10", 32'(y1), 32'd0); #6;
      a1 = 0; b1 = 1; #1 chk("tt_01", 32'(y1), 32'd0); #6;
      a1 = 1; b1 = 1; #1 chk("tt_11", 32'(y1), 32'd1); #6;

      // Reset for two edges with everything driven high.
      @(posedge clk); #2;
      rst = 1; en4 = 1; a4 = 4'hF; b4 = 4'hF;
      #1 chk("rst_Y_pre", 32'(y4), 32'hF);
      step(1);
      chk("rst_Y",    32'(y4),    32'hF);
      chk("rst_Y_q",  32'(yq4),   32'h0);
      chk("rst_all",  32'(all4),  32'd0);
      chk("rst_any",  32'(any4),  32'd0);
      chk("rst_rise", 32'(rise4), 32'd0);
      chk("rst_cnt",  32'(cnt4),  32'd0);
      chk("rst_w1_Y_q", 32'(yq1), 32'd0);
      step(1);
      chk("rst2_Y",   32'(y4),    32'hF);
      chk("rst2_all", 32'(all4),  32'd0);
      rst = 0;

      // Registered path.
      a4 = 4'b1100; b4 = 4'b1010;
      #1 chk("reg_Y_now", 32'(y4), 32'b1000);
      step(1);
      chk("reg_Y_q", 32'(yq4), 32'b1000);
      chk("reg_any", 32'(any4), 32'd1);
      chk("reg_all", 32'(all4), 32'd0);
      a4 = 4'hF; b4 = 4'hF; a1 = 1; b1 = 0;
      step(1);
      chk("ones_all",  32'(all4),  32'd1);
      chk("ones_rise", 32'(rise4), 32'd1);
      step(1);
      chk("ones_rise_drop", 32'(rise4), 32'd0);
      chk("ones_cnt1",      32'(cnt4),  32'd1);

      // Enable hold.
      a4 = 4'b1100; b4 = 4'b1010; a1 = 1; b1 = 1;
      step(1);
      chk("hold_pre_Y_q", 32'(yq4),  32'b1000);
      chk("hold_pre_cnt", 32'(cnt4), 32'd2);
      en4 = 0; a4 = 4'h0; b4 = 4'h0;
      #1 chk("hold_Y_now", 32'(y4), 32'h0);
      step(2);
      chk("hold_Y_q",  32'(yq4),   32'b1000);
      chk("hold_rise", 32'(rise4), 32'd0);
      chk("hold_any",  32'(any4),  32'd1);
      en4 = 1;
      step(1);
      chk("unhold_Y_q", 32'(yq4), 32'h0);
      chk("unhold_any", 32'(any4), 32'd0);

      // Disabled while the AND is all-ones: no pulse until enabled.
      en4 = 0; a4 = 4'hF; b4 = 4'hF;
      step(1);
      chk("dis_rise", 32'(rise4), 32'd0);
      chk("dis_all",  32'(all4),  32'd0);
      en4 = 1;
      step(1);
      chk("en_rise", 32'(rise4), 32'd1);
      a4 = 4'h0; a1 = 0;
      step(1);

      // Counter: clear, then run into saturation.
      clr4 = 1;
      step(1);
      chk("clr_cnt0", 32'(cnt4), 32'd0);
      clr4 = 0; a4 = 4'hF; b4 = 4'hF;
      step(1);
      chk("cnt_rise", 32'(rise4), 32'd1);
      chk("cnt_start", 32'(cnt4), 32'd0);
      for (int k = 1; k <= 10; k++) begin
         step(1);
         chk($sformatf("cnt_k%0d", k), 32'(cnt4), 32'((k > 7) ? 7 : k));
      end
      chk("model_sat", 32'(m_cnt), 32'd7);
      chk("sat_rise",  32'(rise4), 32'd0);

      // Clear beats increment, then counting resumes.
      clr4 = 1;
      step(1);
      chk("clr_wins", 32'(cnt4), 32'd0);
      clr4 = 0;
      step(1);
      chk("resume1", 32'(cnt4), 32'd1);
      step(4);
      chk("resume5", 32'(cnt4), 32'd5);
      chk("model_5", 32'(m_cnt), 32'd5);

      // Reset mid-count; Y keeps tracking the inputs throughout.
      rst = 1; a4 = 4'h3;
      #1 chk("midrst_Y", 32'(y4), 32'h3);
      step(1);
      chk("midrst_cnt", 32'(cnt4), 32'd0);
      chk("midrst_all", 32'(all4), 32'd0);
      chk("midrst_Y2",  32'(y4),   32'h3);
      rst = 0;
      step(1);
      chk("post_Y_q", 32'(yq4),  32'h3);
      chk("post_any", 32'(any4), 32'd1);
      chk("post_cnt", 32'(cnt4), 32'd0);
      step(1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/and_gate.md
Name: and_gate

Overview:
- Parameterisable bitwise two-input AND gate.
- Combinational output Y, plus a registered copy and a small activity monitor (reductions, edge pulse, saturating high-cycle counter).
- Used as a glue/qualifier primitive where both a zero-latency result and a clocked, observable result are needed.
- Y is purely combinational, so a bench without a clock can check Y directly from A and B.

Parameters:
- WIDTH, 1, bit width of A, B, Y, Y_q.
- CNT_W, 16, width of the high-cycle counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- en  input  1  register/monitor update enable. Tie high when unused.
- clr_cnt  input  1  synchronous counter clear.
- Y  output  WIDTH  combinational A & B.
- Y_q  output  WIDTH  registered A & B.
- all_q  output  1  registered reduction-AND of (A & B).
- any_q  output  1  registered reduction-OR of (A & B).
- rise_p  output  1  one-cycle pulse on all_q 0->1 transition.
- hi_cnt  output  CNT_W  saturating count of cycles with all_q = 1.

Behaviour:
Combinational output:
- Y = A & B, bitwise, zero latency.
- Y ignores clk, rst and en.
- X/Z inputs propagate per standard Verilog & semantics: 0 & X = 0.

Reset (rst = 1 at a rising clk edge):
- Y_q = 0, all_q = 0, any_q = 0, rise_p = 0, hi_cnt = 0.
- rst has priority over en and clr_cnt.
- Reset asserted mid-operation takes effect at the next edge. Y is unaffected.

Register update (rst = 0, en = 1):
- Y_q <= A & B.
- all_q <= &(A & B).
- any_q <= |(A & B).
- Latency 1 cycle from A/B to each of these.

Hold (rst = 0, en = 0):
- Y_q, all_q, any_q hold their values.
- rise_p <= 0.
- hi_cnt holds, except that clr_cnt still applies.

rise_p:
- Registered edge detect: rise_p <= en & ~all_q & (&(A & B)).
- High exactly one cycle, in the same cycle all_q first becomes 1.
- Asserts again only after all_q has returned to 0.

hi_cnt, evaluated each edge with rst = 0:
- If clr_cnt = 1: hi_cnt <= 0.
- Else if all_q = 1 and hi_cnt != 2^CNT_W - 1: hi_cnt <= hi_cnt + 1.
- Otherwise hold.
- The count is based on the registered all_q, so it lags all_q by one cycle.
- Saturates at all-ones and never wraps.
- clr_cnt asserted together with a qualifying all_q gives 0: clear wins.

WIDTH = 1 case:
- all_q and any_q both equal Y_q.

No internal state machine beyond the registers above.

Test Plan:
- Combinational truth table, no clock, WIDTH = 1: A,B = 00, 10, 01, 11, each held 7 time units -> Y = 0, 0, 0, 1, settling within the same time step.
- Reset: drive A = B = 1 and en = 1, assert rst for 2 edges -> Y = 1 throughout; Y_q, all_q, any_q, rise_p and hi_cnt all 0 after the first edge.
- Registered path, WIDTH = 4, en = 1: A = 4'b1100, B = 4'b1010 -> Y = 4'b1000 immediately; Y_q = 4'b1000, any_q = 1, all_q = 0 after 1 edge. Then A = B = 4'hF -> all_q = 1 with rise_p = 1 for exactly one cycle.
- Enable hold: with Y_q = 4'b1000, set en = 0 and change A = B = 0 -> Y = 0 immediately while Y_q stays 4'b1000 and rise_p = 0. Restoring en = 1 updates Y_q to 0 on the next edge.
- Counter, CNT_W = 3: hold all_q = 1 for 10 cycles -> hi_cnt goes 1, 2, ... 7 then stays at 7. Asserting clr_cnt while all_q = 1 -> hi_cnt = 0 on that edge, then resumes incrementing.
- Reset mid-count: with hi_cnt = 5, pulse rst for one edge -> hi_cnt = 0 and all_q = 0 on that edge. Y still tracks A & B combinationally during the reset.
